// File: rtl/apb_pkg.sv
// Shared APB slave types: FSM state encoding, counter width,
// and the parameter legality limits checked at elaboration.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int WS_MIN = 0;
  localparam int WS_MAX = 15;
  localparam int CNT_W  = 4;

  localparam int DW_8  = 8;
  localparam int DW_16 = 16;
  localparam int DW_32 = 32;

  function automatic bit dw_legal(input int dw);
    return (dw == DW_8) || (dw == DW_16) || (dw == DW_32);
  endfunction

  function automatic bit ws_legal(input int ws);
    return (ws >= WS_MIN) && (ws <= WS_MAX);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage with byte-lane write strobes, async clear to 0.
// Ports: clk, rst_n, we_i, idx_i, wdata_i, strb_i, rdata_o (comb read).
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IW-1:0]         idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NB-1:0]         strb_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave with programmable wait states and range error.
// Ports: clk, rst_n, psel, penable, pwrite, paddr, pwdata, pstrb -> pready, prdata, pslverr.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int WIW = ADDR_WIDTH - OFF;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W:0]   WS_EXT = (CNT_W+1)'(WAIT_STATES);

  if (!dw_legal(DATA_WIDTH)) begin : g_bad_dw
    $error("apb_mem_slave: DATA_WIDTH must be 8, 16 or 32");
  end
  if (!ws_legal(WAIT_STATES)) begin : g_bad_ws
    $error("apb_mem_slave: WAIT_STATES must be 0..15");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("apb_mem_slave: DEPTH must be >= 1");
  end
  if (WIW < IW || WIW > 32) begin : g_bad_aw
    $error("apb_mem_slave: ADDR_WIDTH cannot address DEPTH words");
  end

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [WIW-1:0]        widx;
  logic                  in_rng;
  logic                  mem_we;
  logic                  hit;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rd_val;

  assign widx   = paddr[ADDR_WIDTH-1:OFF];
  assign in_rng = 32'(widx) < 32'(DEPTH);

  if (OFF > 0) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^paddr[OFF-1:0];
  end

  // Last wait cycle: the counter is one short of WAIT_STATES, so
  // pready rises after edge T0+WAIT_STATES.
  assign hit = ({1'b0, cnt_q} + 1'b1) == WS_EXT;

  assign rd_val = (in_rng && !pwrite) ? mem_rdata : '0;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .idx_i   (widx[IW-1:0]),
    .wdata_i (pwdata),
    .strb_i  (pstrb),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          // Zero wait states: complete in the first access cycle.
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = !in_rng;
            prdata_d  = rd_val;
          end
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (pready_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mem_we  = penable && pwrite && in_rng;
        end else if (penable) begin
          if (cnt_q != WS_CNT) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (hit) begin
            pready_d  = 1'b1;
            pslverr_d = !in_rng;
            prdata_d  = rd_val;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: WAIT_STATES=2 and =0 instances
// on a shared bus, byte-array model, per-cycle output compare.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel2, psel0, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        rdy2, rdy0, err2, err0;
  logic [31:0] rd2, rd0;

  logic        e_rdy2, e_rdy0, e_err2, e_err0;
  logic [31:0] e_rd2, e_rd0;

  logic [7:0]  m2 [256];
  logic [7:0]  m0 [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32),
    .DEPTH(64), .WAIT_STATES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel2),
    .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(rdy2), .prdata(rd2), .pslverr(err2)
  );

  apb_mem_slave #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32),
    .DEPTH(64), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0),
    .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(rdy0), .prdata(rd0), .pslverr(err0)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pready_ws2",  32'(rdy2), 32'(e_rdy2));
    chk("prdata_ws2",  rd2,       e_rd2);
    chk("pslverr_ws2", 32'(err2), 32'(e_err2));
    chk("pready_ws0",  32'(rdy0), 32'(e_rdy0));
    chk("prdata_ws0",  rd0,       e_rd0);
    chk("pslverr_ws0", 32'(err0), 32'(e_err0));
  end

  function automatic logic in_rng(input logic [11:0] a);
    return (a >> 2) < 12'd64;
  endfunction

  function automatic logic [31:0] mrd(input bit w0,
                                      input logic [11:0] a);
    logic [31:0] v;
    int base;
    v = '0;
    if (in_rng(a)) begin
      base = int'(a) & ~3;
      for (int b = 0; b < 4; b++)
        v[8*b +: 8] = w0 ? m0[base+b] : m2[base+b];
    end
    return v;
  endfunction

  task automatic mwr(input bit w0, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    int base;
    base = int'(a) & ~3;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (w0) m0[base+b] = d[8*b +: 8];
        else    m2[base+b] = d[8*b +: 8];
      end
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 256; i++) begin
      m0[i] = 8'h00;
      m2[i] = 8'h00;
    end
  endtask

  task automatic setexp(input bit w0, input logic r,
                        input logic [31:0] d, input logic e);
    if (w0) begin
      e_rdy0 = r; e_rd0 = d; e_err0 = e;
    end else begin
      e_rdy2 = r; e_rd2 = d; e_err2 = e;
    end
  endtask

  task automatic idle_bus();
    psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
  endtask

  task automatic xfer(input bit w0, input bit wr,
                      input logic [11:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] rdv,
                      output logic errv,
                      output int kr);
    int ws;
    logic [31:0] erd;
    logic eer;
    ws = w0 ? 0 : 2;
    rdv = '0; errv = 1'b0; kr = 0;
    eer = !in_rng(a);
    erd = wr ? 32'h0 : mrd(w0, a);
    psel2 = !w0; psel0 = w0; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    setexp(w0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= ws + 1; k++) begin
      if (k == ws + 1) setexp(w0, 1'b1, erd, eer);
      else             setexp(w0, 1'b0, 32'h0, 1'b0);
      if (w0 ? rdy0 : rdy2) begin
        kr = k;
        rdv = w0 ? rd0 : rd2;
        errv = w0 ? err0 : err2;
      end
      @(posedge clk); #1;
    end
    if (wr && in_rng(a)) mwr(w0, a, d, s);
    setexp(w0, 1'b0, 32'h0, 1'b0);
    idle_bus();
  endtask

  logic [31:0] rv;
  logic        ev;
  int          kv;

  initial begin
    idle_bus();
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    setexp(1'b0, 1'b0, 32'h0, 1'b0);
    setexp(1'b1, 1'b0, 32'h0, 1'b0);
    mclear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, rv, ev, kv);
    chk("wr010_k", 32'(kv), 32'd3);
    chk("wr010_err", 32'(ev), 32'd0);
    xfer(0, 0, 12'h010, 32'h0, 4'h0, rv, ev, kv);
    chk("rd010_data", rv, 32'hDEADBEEF);
    chk("rd010_k", 32'(kv), 32'd3);
    chk("rd010_err", 32'(ev), 32'd0);

    xfer(0, 1, 12'h020, 32'h11223344, 4'hF, rv, ev, kv);
    xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'h5, rv, ev, kv);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, rv, ev, kv);
    chk("rd020_strb", rv, 32'h11BB33DD);

    xfer(0, 0, 12'h100, 32'h0, 4'h0, rv, ev, kv);
    chk("rd100_err", 32'(ev), 32'd1);
    chk("rd100_data", rv, 32'h0);
    xfer(0, 0, 12'h0FC, 32'h0, 4'h0, rv, ev, kv);
    chk("rd0fc_err", 32'(ev), 32'd0);

    xfer(0, 1, 12'h010, 32'h12345678, 4'h0, rv, ev, kv);
    chk("strb0_err", 32'(ev), 32'd0);
    chk("strb0_k", 32'(kv), 32'd3);
    xfer(0, 0, 12'h013, 32'h0, 4'h0, rv, ev, kv);
    chk("rd013_offs", rv, 32'hDEADBEEF);

    xfer(0, 1, 12'h104, 32'hFFFFFFFF, 4'hF, rv, ev, kv);
    chk("wr104_err", 32'(ev), 32'd1);
    xfer(0, 0, 12'h004, 32'h0, 4'h0, rv, ev, kv);
    chk("rd004_alias", rv, 32'h0);

    // penable with psel in IDLE must be ignored
    psel2 = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 12'h018; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    xfer(0, 0, 12'h018, 32'h0, 4'h0, rv, ev, kv);
    chk("rd018_ign", rv, 32'h0);
    chk("rd018_k", 32'(kv), 32'd3);

    // abort after one access cycle
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h008; pwdata = 32'h87654321; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("abort_rdy1", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    chk("abort_rdy2", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    chk("abort_rdy3", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    xfer(0, 0, 12'h008, 32'h0, 4'h0, rv, ev, kv);
    chk("rd008_abort", rv, 32'h0);
    chk("rd008_k", 32'(kv), 32'd3);

    xfer(1, 1, 12'h000, 32'hCAFEF00D, 4'hF, rv, ev, kv);
    chk("ws0_wr0_k", 32'(kv), 32'd1);
    xfer(1, 1, 12'h004, 32'h01020304, 4'hF, rv, ev, kv);
    chk("ws0_wr4_k", 32'(kv), 32'd1);
    xfer(1, 0, 12'h000, 32'h0, 4'h0, rv, ev, kv);
    chk("ws0_rd0", rv, 32'hCAFEF00D);
    chk("ws0_rd0_k", 32'(kv), 32'd1);
    xfer(1, 0, 12'h004, 32'h0, 4'h0, rv, ev, kv);
    chk("ws0_rd4", rv, 32'h01020304);
    xfer(1, 0, 12'h200, 32'h0, 4'h0, rv, ev, kv);
    chk("ws0_oor_err", 32'(ev), 32'd1);

    // reset in the pready cycle of a write to 0x00C
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h00C; pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      setexp(0, (k == 3), 32'h0, 1'b0);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("rst_pre_rdy", 32'(rdy2), 32'd1);
    #2 rst_n = 1'b0;
    mclear();
    setexp(0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rst_rdy_now", 32'(rdy2), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 12'h00C, 32'h0, 4'h0, rv, ev, kv);
    chk("rd00c_rst", rv, 32'h0);
    chk("rd00c_k", 32'(kv), 32'd3);
    xfer(0, 0, 12'h010, 32'h0, 4'h0, rv, ev, kv);
    chk("rd010_rst", rv, 32'h0);
    xfer(1, 0, 12'h000, 32'h0, 4'h0, rv, ev, kv);
    chk("ws0_rd0_rst", rv, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
